// File: rtl/pipe_stage_buf.sv
// Generic inter-stage pipeline register with valid/ready handshake.
// Optional 2-entry skid buffer; empty slots present NOP_VALUE.
module pipe_stage_buf #(
  parameter int unsigned          PAYLOAD_W = 80,
  parameter logic [PAYLOAD_W-1:0] NOP_VALUE = '0,
  parameter bit                   SKID      = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] out_payload,
  input  logic                 out_ready,
  output logic [1:0]           occupancy
);

  logic acc;
  logic pop;

  assign acc = in_valid & in_ready;
  assign pop = out_valid & out_ready;

  if (SKID) begin : g_skid
    typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
    } state_e;

    state_e               state_q;
    state_e               state_d;
    logic                 rdy_q;
    logic [PAYLOAD_W-1:0] main_q;
    logic [PAYLOAD_W-1:0] main_d;
    logic [PAYLOAD_W-1:0] skid_q;
    logic [PAYLOAD_W-1:0] skid_d;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= EMPTY;
        rdy_q   <= 1'b1;
      end else begin
        state_q <= state_d;
        rdy_q   <= (state_d != TWO);
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        main_q <= NOP_VALUE;
        skid_q <= NOP_VALUE;
      end else begin
        main_q <= main_d;
        skid_q <= skid_d;
      end
    end

    // Flush takes priority so a squashed input never lands in a slot.
    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
        state_d = EMPTY;
      end else begin
        unique case (state_q)
          EMPTY: begin
            if (acc) begin
              state_d = ONE;
              main_d  = in_payload;
            end
          end
          ONE: begin
            if (acc && pop) begin
              main_d = in_payload;
            end else if (acc) begin
              state_d = TWO;
              skid_d  = in_payload;
            end else if (pop) begin
              state_d = EMPTY;
            end
          end
          TWO: begin
            if (pop) begin
              state_d = ONE;
              main_d  = skid_q;
            end
          end
          default: state_d = EMPTY;
        endcase
      end
    end

    always_comb begin
      in_ready    = rdy_q;
      out_valid   = (state_q != EMPTY);
      occupancy   = state_q;
      out_payload = (state_q != EMPTY) ? main_q : NOP_VALUE;
    end

  end else begin : g_single
    logic                 vld_q;
    logic                 vld_d;
    logic [PAYLOAD_W-1:0] main_q;
    logic [PAYLOAD_W-1:0] main_d;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_q  <= 1'b0;
        main_q <= NOP_VALUE;
      end else begin
        vld_q  <= vld_d;
        main_q <= main_d;
      end
    end

    always_comb begin
      vld_d  = vld_q;
      main_d = main_q;
      if (flush) begin
        vld_d = 1'b0;
      end else if (acc) begin
        vld_d  = 1'b1;
        main_d = in_payload;
      end else if (pop) begin
        vld_d = 1'b0;
      end
    end

    always_comb begin
      in_ready    = ~vld_q | out_ready;
      out_valid   = vld_q;
      occupancy   = {1'b0, vld_q};
      out_payload = vld_q ? main_q : NOP_VALUE;
    end
  end

endmodule
